voice_allocator: RTL and testbench

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

---
 rtl/voice_allocator.sv | 162 ++++++++++++++++
 tb/tb_voice_allocator.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: matches, frees or (with VOICE_ALLOC_STEAL_EN)
// steals the oldest voice for each note request over an IDLE/SCAN/COMMIT cycle.
module voice_allocator #(
    parameter int NUM_VOICES = 8,
    parameter int AGE_W      = 8
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    note_valid,
    input  logic                    note_on,
    input  logic [6:0]              note,
    output logic                    note_ready,
    output logic [NUM_VOICES*7-1:0] voice_freq,
    output logic [NUM_VOICES-1:0]   voice_key,
    output logic                    steal_pulse,
    output logic                    drop_pulse
);
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
    state_t state, state_nxt;

    logic                                req_on;
    logic [6:0]                          req_note;
    logic [NUM_VOICES-1:0][6:0]          freq;
    logic [NUM_VOICES-1:0][AGE_W-1:0]    age;
    logic [NUM_VOICES-1:0]               key;

    logic [NUM_VOICES-1:0] hit_c, hit_q;
    logic                  match_hit_c, free_hit_c, match_hit, free_hit;
    logic [IDX_W-1:0]      match_idx_c, free_idx_c, match_idx, free_idx;
    logic [IDX_W-1:0]      old_idx_c, old_idx;

    logic                  tgt_vld, load_freq, steal_c, drop_c;
    logic [IDX_W-1:0]      tgt_idx;

    assign note_ready = (state == IDLE);
    assign voice_freq = freq;
    assign voice_key  = key;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (note_valid) state_nxt = SCAN;
            SCAN:    state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Lowest-index match/free search; oldest active voice, ties to lowest index.
    always_comb begin
        logic [AGE_W-1:0] best_age;
        logic             best_found;
        hit_c       = '0;
        match_hit_c = 1'b0;
        match_idx_c = '0;
        free_hit_c  = 1'b0;
        free_idx_c  = '0;
        old_idx_c   = '0;
        best_age    = '0;
        best_found  = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            hit_c[i] = key[i] && (freq[i] == req_note);
            if (hit_c[i] && !match_hit_c) begin
                match_hit_c = 1'b1;
                match_idx_c = IDX_W'(i);
            end
            if (!key[i] && !free_hit_c) begin
                free_hit_c = 1'b1;
                free_idx_c = IDX_W'(i);
            end
            if (key[i] && (!best_found || age[i] > best_age)) begin
                best_found = 1'b1;
                best_age   = age[i];
                old_idx_c  = IDX_W'(i);
            end
        end
    end

    always_comb begin
        tgt_vld   = 1'b0;
        tgt_idx   = '0;
        load_freq = 1'b0;
        steal_c   = 1'b0;
        drop_c    = 1'b0;
        if (req_on) begin
            if (match_hit) begin
                tgt_vld = 1'b1;
                tgt_idx = match_idx;
            end else if (free_hit) begin
                tgt_vld   = 1'b1;
                tgt_idx   = free_idx;
                load_freq = 1'b1;
            end else begin
`ifdef VOICE_ALLOC_STEAL_EN
                tgt_vld   = 1'b1;
                tgt_idx   = old_idx;
                load_freq = 1'b1;
                steal_c   = 1'b1;
`else
                drop_c    = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            req_on      <= 1'b0;
            req_note    <= '0;
            hit_q       <= '0;
            match_hit   <= 1'b0;
            match_idx   <= '0;
            free_hit    <= 1'b0;
            free_idx    <= '0;
            old_idx     <= '0;
            freq        <= '0;
            age         <= '0;
            key         <= '0;
            steal_pulse <= 1'b0;
            drop_pulse  <= 1'b0;
        end else begin
            steal_pulse <= 1'b0;
            drop_pulse  <= 1'b0;
            if (state == IDLE && note_valid) begin
                req_on   <= note_on;
                req_note <= note;
            end
            if (state == SCAN) begin
                hit_q     <= hit_c;
                match_hit <= match_hit_c;
                match_idx <= match_idx_c;
                free_hit  <= free_hit_c;
                free_idx  <= free_idx_c;
                old_idx   <= old_idx_c;
            end
            if (state == COMMIT) begin
                steal_pulse <= steal_c;
                drop_pulse  <= drop_c;
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (!req_on) begin
                        if (hit_q[i]) key[i] <= 1'b0;
                    end else if (tgt_vld) begin
                        if (IDX_W'(i) == tgt_idx) begin
                            age[i] <= '0;
                            key[i] <= 1'b1;
                            if (load_freq) freq[i] <= req_note;
                        end else if (key[i] && age[i] != {AGE_W{1'b1}}) begin
                            age[i] <= age[i] + 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: vector table plus reset/idle corner sequences.
module tb_voice_allocator;
    logic        Clk = 1'b0, Reset_n = 1'b0, note_valid = 1'b0, note_on = 1'b0;
    logic [6:0]  note = '0;
    logic        note_ready, steal_pulse, drop_pulse;
    logic [55:0] voice_freq;
    logic [7:0]  voice_key;
    int checks = 0, errors = 0;

`ifdef VOICE_ALLOC_STEAL_EN
    localparam bit STEAL = 1'b1;
`else
    localparam bit STEAL = 1'b0;
`endif

    always #5 Clk = ~Clk;

    voice_allocator #(.NUM_VOICES(8), .AGE_W(8)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .note_valid(note_valid), .note_on(note_on),
        .note(note), .note_ready(note_ready), .voice_freq(voice_freq),
        .voice_key(voice_key), .steal_pulse(steal_pulse), .drop_pulse(drop_pulse)
    );

    typedef struct {
        bit         rst;
        bit         on;
        logic [6:0] n;
        logic [7:0] key;
        int         fidx;
        logic [6:0] fval;
        bit         st;
        bit         dr;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset_n = 1'b0;
        #2;
        Reset_n = 1'b1;
    endtask

    task automatic send(input bit on, input logic [6:0] n);
        int w = 0;
        @(negedge Clk);
        while (!note_ready && w < 20) begin
            @(negedge Clk);
            w++;
        end
        chk("ready_before_accept", note_ready, 1);
        note_valid = 1'b1;
        note_on    = on;
        note       = n;
        @(posedge Clk);
        #1;
        // Scramble request fields after accept; they must already be captured.
        note_valid = 1'b0;
        note_on    = ~on;
        note       = ~n;
        chk("ready_low_cycle1", note_ready, 0);
        @(posedge Clk);
        #1;
        chk("ready_low_cycle2", note_ready, 0);
        @(posedge Clk);
        #1;
        chk("ready_high_after_commit", note_ready, 1);
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{1, 1, 60, 8'h01, 0, 60, 0, 0});
        vecs.push_back('{0, 1, 60, 8'h01, 0, 60, 0, 0});
        vecs.push_back('{0, 1, 62, 8'h03, 1, 62, 0, 0});
        vecs.push_back('{0, 1, 64, 8'h07, 2, 64, 0, 0});
        vecs.push_back('{0, 0, 62, 8'h05, 1, 62, 0, 0});
        vecs.push_back('{0, 0, 99, 8'h05, 2, 64, 0, 0});
        vecs.push_back('{0, 0, 60, 8'h04, 0, 60, 0, 0});
        for (int i = 0; i < 8; i++)
            vecs.push_back('{(i == 0), 1, 7'(40 + i), 8'((1 << (i + 1)) - 1), i, 7'(40 + i), 0, 0});
        vecs.push_back('{0, 1, 50, 8'hFF, 0, STEAL ? 7'd50 : 7'd40, STEAL, !STEAL});
        vecs.push_back('{0, 1, 51, 8'hFF, 1, STEAL ? 7'd51 : 7'd41, STEAL, !STEAL});
        vecs.push_back('{0, 1, 45, 8'hFF, 5, 45, 0, 0});
        vecs.push_back('{0, 0, 47, 8'h7F, 7, 47, 0, 0});
        vecs.push_back('{0, 1, 52, 8'hFF, 7, 52, 0, 0});

        // Reset state
        #3;
        chk("rst_key", voice_key, 0);
        chk("rst_freq", voice_freq, 0);
        chk("rst_steal", steal_pulse, 0);
        chk("rst_drop", drop_pulse, 0);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("rst_ready", note_ready, 1);

        foreach (vecs[k]) begin
            if (vecs[k].rst) do_reset();
            send(vecs[k].on, vecs[k].n);
            chk($sformatf("v%0d_key", k), voice_key, vecs[k].key);
            chk($sformatf("v%0d_freq", k), voice_freq[7*vecs[k].fidx +: 7], vecs[k].fval);
            chk($sformatf("v%0d_steal", k), steal_pulse, vecs[k].st);
            chk($sformatf("v%0d_drop", k), drop_pulse, vecs[k].dr);
            @(posedge Clk);
            #1;
            chk($sformatf("v%0d_steal_end", k), steal_pulse, 0);
            chk($sformatf("v%0d_drop_end", k), drop_pulse, 0);
        end

        // Idle with no request: everything holds.
        repeat (5) @(posedge Clk);
        #1;
        chk("idle_key_hold", voice_key, 8'hFF);
        chk("idle_freq7_hold", voice_freq[49 +: 7], 52);
        chk("idle_ready", note_ready, 1);

        // Reset during SCAN aborts the pending note-on.
        do_reset();
        @(negedge Clk);
        note_valid = 1'b1;
        note_on    = 1'b1;
        note       = 7'd60;
        @(posedge Clk);
        #1;
        note_valid = 1'b0;
        chk("abort_in_scan", note_ready, 0);
        Reset_n = 1'b0;
        #1;
        chk("abort_key_async", voice_key, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (3) begin
            @(posedge Clk);
            #1;
            chk("abort_key", voice_key, 0);
            chk("abort_freq", voice_freq, 0);
            chk("abort_ready", note_ready, 1);
            chk("abort_pulses", {steal_pulse, drop_pulse}, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
